// File: rtl/d_hazard_scoreboard_pkg.sv
// Shared constants and slot type for the D-stage hazard scoreboard.
// Tnew ages by one per pipeline shift and saturates at zero.
package d_hazard_scoreboard_pkg;

  localparam int TW     = 2;
  localparam int SLOT_W = 1 + 5 + TW;

  localparam logic [TW-1:0] TUSE_NONE = 2'd3;

  localparam logic [1:0] FWD_GRF = 2'd0;
  localparam logic [1:0] FWD_E   = 2'd1;
  localparam logic [1:0] FWD_M   = 2'd2;

  localparam logic [3:0] MULT_LAT = 4'd5;
  localparam logic [3:0] DIV_LAT  = 4'd10;

  typedef struct packed {
    logic          valid;
    logic [4:0]    dst;
    logic [TW-1:0] tnew;
  } slot_t;

  function automatic logic [TW-1:0] age_tnew(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

endpackage

// File: rtl/d_hazard_scoreboard_operand.sv
// Hazard resolution for one source operand against the E/M/W slots.
// The youngest matching slot decides both the stall and the forward select.
module d_hazard_scoreboard_operand
  import d_hazard_scoreboard_pkg::*;
(
  input  logic [4:0]        r_i,
  input  logic [TW-1:0]     tuse_i,
  input  logic [SLOT_W-1:0] e_slot_i,
  input  logic [SLOT_W-1:0] m_slot_i,
  input  logic [SLOT_W-1:0] w_slot_i,
  output logic              stall_o,
  output logic [1:0]        sel_o
);

  slot_t e_slot;
  slot_t m_slot;
  slot_t w_slot;

  logic          hit;
  logic [TW-1:0] hit_tnew;

  assign e_slot = slot_t'(e_slot_i);
  assign m_slot = slot_t'(m_slot_i);
  assign w_slot = slot_t'(w_slot_i);

  always_comb begin
    hit      = 1'b0;
    hit_tnew = '0;
    sel_o    = FWD_GRF;
    if (r_i != 5'd0) begin
      if (e_slot.valid && (e_slot.dst == r_i)) begin
        hit      = 1'b1;
        hit_tnew = e_slot.tnew;
        if (e_slot.tnew == '0) sel_o = FWD_E;
      end else if (m_slot.valid && (m_slot.dst == r_i)) begin
        hit      = 1'b1;
        hit_tnew = m_slot.tnew;
        if (m_slot.tnew == '0) sel_o = FWD_M;
      end else if (w_slot.valid && (w_slot.dst == r_i)) begin
        // W results reach D through the GRF write-through path.
        hit      = 1'b1;
        hit_tnew = w_slot.tnew;
      end
    end
  end

  assign stall_o = hit && (tuse_i != TUSE_NONE) && (tuse_i < hit_tnew);

endmodule

// File: rtl/d_hazard_scoreboard.sv
// D-stage hazard scoreboard: tracks in-flight destinations and the mult/div
// busy counter, and produces the D-stage stall and operand forward selects.
module d_hazard_scoreboard
  import d_hazard_scoreboard_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          d_valid,
  input  logic [4:0]    d_rs,
  input  logic [4:0]    d_rt,
  input  logic [TW-1:0] d_tuse_rs,
  input  logic [TW-1:0] d_tuse_rt,
  input  logic [4:0]    d_dst,
  input  logic [TW-1:0] d_tnew,
  input  logic          d_md_use,
  input  logic          e_md_start,
  input  logic          e_md_is_div,
  output logic          stall,
  output logic [1:0]    fwd_rs_sel,
  output logic [1:0]    fwd_rt_sel,
  output logic          md_busy
);

  slot_t e_q, e_d;
  slot_t m_q, m_d;
  slot_t w_q, w_d;
  logic [3:0] md_cnt_q, md_cnt_d;

  logic rs_stall;
  logic rt_stall;
  logic md_stall;

  d_hazard_scoreboard_operand u_rs (
    .r_i      (d_rs),
    .tuse_i   (d_tuse_rs),
    .e_slot_i (e_q),
    .m_slot_i (m_q),
    .w_slot_i (w_q),
    .stall_o  (rs_stall),
    .sel_o    (fwd_rs_sel)
  );

  d_hazard_scoreboard_operand u_rt (
    .r_i      (d_rt),
    .tuse_i   (d_tuse_rt),
    .e_slot_i (e_q),
    .m_slot_i (m_q),
    .w_slot_i (w_q),
    .stall_o  (rt_stall),
    .sel_o    (fwd_rt_sel)
  );

  assign md_busy  = (md_cnt_q != 4'd0);
  assign md_stall = d_md_use && (md_busy || e_md_start);

  // Gated by reset so an asserted reset drops stall even while e_md_start is high.
  assign stall = reset && d_valid && (rs_stall || rt_stall || md_stall);

  always_comb begin
    m_d      = e_q;
    m_d.tnew = age_tnew(e_q.tnew);
    w_d      = m_q;
    w_d.tnew = age_tnew(m_q.tnew);
    e_d      = '0;
    if (d_valid && !stall && (d_dst != 5'd0)) begin
      e_d.valid = 1'b1;
      e_d.dst   = d_dst;
      e_d.tnew  = d_tnew;
    end
  end

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (e_md_start) begin
      md_cnt_d = e_md_is_div ? DIV_LAT : MULT_LAT;
    end else if (md_cnt_q != 4'd0) begin
      md_cnt_d = md_cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q      <= '0;
      m_q      <= '0;
      w_q      <= '0;
      md_cnt_q <= '0;
    end else begin
      e_q      <= e_d;
      m_q      <= m_d;
      w_q      <= w_d;
      md_cnt_q <= md_cnt_d;
    end
  end

endmodule

// File: tb/tb_d_hazard_scoreboard.sv
// Directed testbench for d_hazard_scoreboard with hand-computed expectations.
module tb_d_hazard_scoreboard;

  logic       clk;
  logic       reset;
  logic       d_valid;
  logic [4:0] d_rs, d_rt, d_dst;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_md_use, e_md_start, e_md_is_div;
  logic       stall, md_busy;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;

  int n_checks = 0;
  int n_fail   = 0;

  d_hazard_scoreboard dut (
    .clk         (clk),
    .reset       (reset),
    .d_valid     (d_valid),
    .d_rs        (d_rs),
    .d_rt        (d_rt),
    .d_tuse_rs   (d_tuse_rs),
    .d_tuse_rt   (d_tuse_rt),
    .d_dst       (d_dst),
    .d_tnew      (d_tnew),
    .d_md_use    (d_md_use),
    .e_md_start  (e_md_start),
    .e_md_is_div (e_md_is_div),
    .stall       (stall),
    .fwd_rs_sel  (fwd_rs_sel),
    .fwd_rt_sel  (fwd_rt_sel),
    .md_busy     (md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_d(input logic v, input logic [4:0] rs, input logic [1:0] tu_rs,
                         input logic [4:0] rt, input logic [1:0] tu_rt,
                         input logic [4:0] dst, input logic [1:0] tn, input logic md);
    d_valid   = v;
    d_rs      = rs;
    d_tuse_rs = tu_rs;
    d_rt      = rt;
    d_tuse_rt = tu_rt;
    d_dst     = dst;
    d_tnew    = tn;
    d_md_use  = md;
  endtask

  task automatic set_idle();
    drive_d(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0);
    e_md_start  = 1'b0;
    e_md_is_div = 1'b0;
  endtask

  task automatic flush();
    set_idle();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_idle();
    #3;
    n_checks++;
    if (stall !== 1'b0 || fwd_rs_sel !== 2'd0 || fwd_rt_sel !== 2'd0 || md_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_initial: stall=%b rs_sel=%0d rt_sel=%0d busy=%b want 0/0/0/0",
               stall, fwd_rs_sel, fwd_rt_sel, md_busy);
    end
    repeat (2) tick();
    reset = 1'b1;
    tick();
    drive_d(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd5, 2'd3, 1'b0);
    tick();
    drive_d(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd6, 2'd3, 1'b0);
    e_md_start  = 1'b1;
    e_md_is_div = 1'b1;
    tick();
    e_md_start  = 1'b0;
    // E=$6 tnew3, M=$5 tnew2, md_cnt=10
    drive_d(1'b1, 5'd5, 2'd0, 5'd6, 2'd0, 5'd0, 2'd0, 1'b1);
    #1;
    n_checks++;
    if (stall !== 1'b1 || md_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_prefill: stall=%b busy=%b want 1/1", stall, md_busy);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (stall !== 1'b0 || fwd_rs_sel !== 2'd0 || fwd_rt_sel !== 2'd0 || md_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midrun: stall=%b rs_sel=%0d rt_sel=%0d busy=%b want 0/0/0/0",
               stall, fwd_rs_sel, fwd_rt_sel, md_busy);
    end
    set_idle();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_load_use();
    flush();
    drive_d(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd1, 2'd2, 1'b0);
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL load_use_producer: stall=%b want 0", stall);
    end
    tick();
    drive_d(1'b1, 5'd1, 2'd1, 5'd1, 2'd1, 5'd2, 2'd1, 1'b0);
    #1;
    n_checks++;
    if (stall !== 1'b1 || fwd_rs_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL load_use_stall: stall=%b rs_sel=%0d want 1/0", stall, fwd_rs_sel);
    end
    tick();
    // $1 now in M with tnew1: tuse1 satisfied, not yet forwardable
    #1;
    n_checks++;
    if (stall !== 1'b0 || fwd_rs_sel !== 2'd0 || fwd_rt_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL load_use_release: stall=%b rs_sel=%0d rt_sel=%0d want 0/0/0",
               stall, fwd_rs_sel, fwd_rt_sel);
    end
    tick();
    drive_d(1'b1, 5'd2, 2'd1, 5'd1, 2'd0, 5'd0, 2'd0, 1'b0);
    #1;
    n_checks++;
    if (stall !== 1'b0 || fwd_rs_sel !== 2'd0 || fwd_rt_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL load_use_wslot: stall=%b rs_sel=%0d rt_sel=%0d want 0/0/0",
               stall, fwd_rs_sel, fwd_rt_sel);
    end
    tick();
  endtask

  task automatic test_alu_branch();
    flush();
    drive_d(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd3, 2'd1, 1'b0);
    tick();
    drive_d(1'b1, 5'd3, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0);
    #1;
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL branch_stall: stall=%b want 1", stall);
    end
    tick();
    #1;
    n_checks++;
    if (stall !== 1'b0 || fwd_rs_sel !== 2'd2) begin
      n_fail++;
      $display("FAIL branch_fwd_m: stall=%b rs_sel=%0d want 0/2", stall, fwd_rs_sel);
    end
    tick();
    drive_d(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd7, 2'd0, 1'b0);
    tick();
    drive_d(1'b1, 5'd0, 2'd0, 5'd7, 2'd0, 5'd0, 2'd0, 1'b0);
    #1;
    n_checks++;
    if (stall !== 1'b0 || fwd_rt_sel !== 2'd1 || fwd_rs_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL fwd_from_e: stall=%b rs_sel=%0d rt_sel=%0d want 0/0/1",
               stall, fwd_rs_sel, fwd_rt_sel);
    end
    tick();
  endtask

  task automatic test_zero_reg();
    flush();
    drive_d(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd2, 1'b0);
    tick();
    drive_d(1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd2, 1'b0);
    #1;
    n_checks++;
    if (stall !== 1'b0 || fwd_rs_sel !== 2'd0 || fwd_rt_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL zero_reg: stall=%b rs_sel=%0d rt_sel=%0d want 0/0/0",
               stall, fwd_rs_sel, fwd_rt_sel);
    end
    tick();
  endtask

  task automatic test_youngest();
    flush();
    drive_d(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd4, 2'd0, 1'b0);
    tick();
    tick();
    drive_d(1'b1, 5'd4, 2'd0, 5'd4, 2'd0, 5'd0, 2'd0, 1'b0);
    #1;
    n_checks++;
    if (stall !== 1'b0 || fwd_rs_sel !== 2'd1 || fwd_rt_sel !== 2'd1) begin
      n_fail++;
      $display("FAIL youngest_e: stall=%b rs_sel=%0d rt_sel=%0d want 0/1/1",
               stall, fwd_rs_sel, fwd_rt_sel);
    end
    flush();
    drive_d(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd4, 2'd0, 1'b0);
    tick();
    drive_d(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd4, 2'd2, 1'b0);
    tick();
    // E=$4 tnew2 shadows the ready M=$4
    drive_d(1'b1, 5'd4, 2'd1, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0);
    #1;
    n_checks++;
    if (stall !== 1'b1 || fwd_rs_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL youngest_not_ready: stall=%b rs_sel=%0d want 1/0", stall, fwd_rs_sel);
    end
    d_tuse_rs = 2'd2;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL tuse_eq_tnew: stall=%b want 0", stall);
    end
    d_tuse_rs = 2'd3;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL tuse_none: stall=%b want 0", stall);
    end
    d_valid   = 1'b0;
    d_tuse_rs = 2'd0;
    d_md_use  = 1'b1;
    e_md_start = 1'b1;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL invalid_no_stall: stall=%b want 0", stall);
    end
    set_idle();
    tick();
  endtask

  task automatic test_mdu(input logic is_div, input int exp_cycles);
    int cnt;
    flush();
    repeat (12) tick();
    drive_d(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 2'd1, 1'b1);
    e_md_start  = 1'b1;
    e_md_is_div = is_div;
    #1;
    n_checks++;
    if (stall !== 1'b1 || md_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mdu_start div=%0d: stall=%b busy=%b want 1/0", is_div, stall, md_busy);
    end
    cnt = 1;
    tick();
    e_md_start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (!stall) break;
      cnt++;
      tick();
    end
    n_checks++;
    if (cnt != exp_cycles) begin
      n_fail++;
      $display("FAIL mdu_stall_len div=%0d: got %0d cycles want %0d", is_div, cnt, exp_cycles);
    end
    n_checks++;
    if (md_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mdu_idle div=%0d: busy=%b want 0", is_div, md_busy);
    end
    set_idle();
    tick();
  endtask

  initial begin
    set_idle();
    test_reset();
    test_load_use();
    test_alu_branch();
    test_zero_reg();
    test_youngest();
    test_mdu(1'b1, 11);
    test_mdu(1'b0, 6);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
